// File: rtl/sram_burst_pkg.sv
// Shared types and helpers for the sram burst controller.
// - state_e     : controller FSM states
// - addr_width  : address width derived from sram depth
// - cnt_width   : beat-counter width derived from burst length
// - beat_addr   : address of beat k of a burst that wraps inside its aligned block
package sram_burst_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StDrain
    } state_e;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned bl);
        return $clog2(bl);
    endfunction

    // Upper bits come from the base; the low log2(bl) bits step and wrap, so a
    // burst never leaves its bl-aligned block. bl must be a power of 2.
    function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                              input logic [31:0] k,
                                              input int unsigned bl);
        logic [31:0] mask;
        mask = bl - 1;
        return (base & ~mask) | ((base + k) & mask);
    endfunction

endpackage

// File: rtl/sram_burst_ctrl_addr_gen.sv
// burst_addr_gen: holds the burst base address and beat counter, and produces
// the wrapped address of the current beat.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : latch base_i and clear the beat counter
//   base_i    : burst start address
//   adv_i     : advance to the next beat
//   addr_o    : address of the current beat
//   last_o    : current beat is the final one of the burst
module burst_addr_gen
    import sram_burst_pkg::*;
#(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned BL    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic [addr_width(DEPTH)-1:0]  base_i,
    input  logic                          adv_i,
    output logic [addr_width(DEPTH)-1:0]  addr_o,
    output logic                          last_o
);

    localparam int unsigned AW = addr_width(DEPTH);
    localparam int unsigned CW = cnt_width(BL);

    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            base_d = base_i;
            cnt_d  = '0;
        end else if (adv_i) begin
            // Natural CW-bit wrap returns the counter to 0 after the last beat.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o = AW'(beat_addr(32'(base_q), 32'(cnt_q), BL));
    assign last_o = (cnt_q == CW'(BL - 1));

endmodule

// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: accepts read/write burst requests and expands each into BL
// single-beat sram accesses in wrapped sequential order.
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready/req_wr/addr  : burst request handshake
//   wdata_valid/wdata_ready/wdata    : write beat handshake
//   rdata_valid/rdata/rdata_last     : read beat stream, no backpressure
//   busy                             : controller not idle
//   sram_addr/sram_rd_o_wr/i_data    : sram command side
//   sram_o_data                      : sram read data, one-cycle latency
module sram_burst_ctrl
    import sram_burst_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned BL    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [addr_width(DEPTH)-1:0]  req_addr,
    input  logic                          wdata_valid,
    output logic                          wdata_ready,
    input  logic [WIDTH-1:0]              wdata,
    output logic                          rdata_valid,
    output logic [WIDTH-1:0]              rdata,
    output logic                          rdata_last,
    output logic                          busy,
    output logic [addr_width(DEPTH)-1:0]  sram_addr,
    output logic                          sram_rd_o_wr,
    output logic [WIDTH-1:0]              sram_i_data,
    input  logic [WIDTH-1:0]              sram_o_data
);

    localparam int unsigned AW = addr_width(DEPTH);

    state_e        state_q, state_d;
    logic          rdata_valid_q, rdata_last_q;
    logic          load, adv, issue, beat_last;
    logic [AW-1:0] beat_addr_w;

    burst_addr_gen #(
        .DEPTH (DEPTH),
        .BL    (BL)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (req_valid & req_ready),
        .base_i (req_addr),
        .adv_i  (adv),
        .addr_o (beat_addr_w),
        .last_o (beat_last)
    );

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        wdata_ready  = 1'b0;
        busy         = 1'b0;
        sram_addr    = '0;
        sram_rd_o_wr = 1'b0;
        sram_i_data  = '0;
        load         = 1'b0;
        adv          = 1'b0;
        issue        = 1'b0;
        // Everything stays quiet while rst is high so no beat leaks into the sram.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        load    = 1'b1;
                        state_d = req_wr ? StWr : StRd;
                    end
                end
                StWr: begin
                    busy        = 1'b1;
                    wdata_ready = 1'b1;
                    if (wdata_valid) begin
                        sram_rd_o_wr = 1'b1;
                        sram_addr    = beat_addr_w;
                        sram_i_data  = wdata;
                        adv          = 1'b1;
                        if (beat_last) state_d = StIdle;
                    end
                end
                StRd: begin
                    busy      = 1'b1;
                    issue     = 1'b1;
                    sram_addr = beat_addr_w;
                    adv       = 1'b1;
                    if (beat_last) state_d = StDrain;
                end
                StDrain: begin
                    // Lets the final read beat come back before a new request.
                    busy    = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdata_valid_q <= issue;
            rdata_last_q  <= issue & beat_last;
        end
    end

    // load is informational only; the sub-module latches on the raw handshake.
    logic unused_load;
    assign unused_load = load;

    assign rdata_valid = rdata_valid_q & ~rst;
    assign rdata_last  = rdata_last_q & ~rst;
    assign rdata       = sram_o_data;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
module tb_sram_burst_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2048;
    localparam int BL    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [10:0] req_addr;
    logic        wdata_valid, wdata_ready;
    logic [7:0]  wdata;
    logic        rdata_valid, rdata_last, busy;
    logic [7:0]  rdata;
    logic [10:0] sram_addr;
    logic        sram_rd_o_wr;
    logic [7:0]  sram_i_data;
    logic [7:0]  sram_o_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    logic       mem_load;

    always #5 clk = ~clk;

    sram_burst_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BL    (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .wdata_valid  (wdata_valid),
        .wdata_ready  (wdata_ready),
        .wdata        (wdata),
        .rdata_valid  (rdata_valid),
        .rdata        (rdata),
        .rdata_last   (rdata_last),
        .busy         (busy),
        .sram_addr    (sram_addr),
        .sram_rd_o_wr (sram_rd_o_wr),
        .sram_i_data  (sram_i_data),
        .sram_o_data  (sram_o_data)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    // Simple sram: registered read, write at clock edge.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (sram_rd_o_wr) begin
            mem[sram_addr] <= sram_i_data;
        end
        sram_o_data <= mem[sram_addr];
    end

    function automatic logic [10:0] ref_addr(input logic [10:0] base, input int k);
        int b;
        b = int'(base);
        return 11'((b / BL) * BL + ((b % BL) + k) % BL);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts at a cycle boundary with inputs free; ends at the first cycle after the burst.
    task automatic run_burst(input bit wr, input logic [10:0] base, input logic [7:0] d0,
                             input bit toggle, input bit hold,
                             output logic [7:0] first, output logic [7:0] last);
        int k;
        int c;
        req_valid   = 1'b1;
        req_wr      = wr;
        req_addr    = base;
        wdata_valid = 1'b0;
        #1;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("idle_no_write", 32'(sram_rd_o_wr), 32'd0);
        tick();
        if (!hold) begin
            req_valid = 1'b0;
            req_addr  = 11'($urandom);
        end
        first = '0;
        last  = '0;
        if (wr) begin
            k = 0;
            c = 0;
            while (k < BL && c < 4 * BL) begin
                wdata_valid = toggle ? (c % 2 == 0) : 1'b1;
                wdata       = d0 + 8'(k);
                #1;
                check("wdata_ready", 32'(wdata_ready), 32'd1);
                check("busy_wr", 32'(busy), 32'd1);
                check("wr_strobe", 32'(sram_rd_o_wr), 32'(wdata_valid));
                if (wdata_valid) begin
                    check("wr_addr", 32'(sram_addr), 32'(ref_addr(base, k)));
                    check("wr_data", 32'(sram_i_data), 32'(wdata));
                    ref_mem[ref_addr(base, k)] = wdata;
                    k++;
                end
                tick();
                c++;
            end
            wdata_valid = 1'b0;
            check("wr_beats", 32'(k), 32'(BL));
            #1;
            check("req_ready_after_wr", 32'(req_ready), 32'd1);
            check("busy_after_wr", 32'(busy), 32'd0);
        end else begin
            for (c = 1; c <= BL + 1; c++) begin
                wdata_valid = 1'($urandom_range(0, 1));
                #1;
                check("rd_no_write", 32'(sram_rd_o_wr), 32'd0);
                check("rd_wdata_ready", 32'(wdata_ready), 32'd0);
                check("rd_busy", 32'(busy), 32'd1);
                check("rd_req_ready", 32'(req_ready), 32'd0);
                check("rdata_valid", 32'(rdata_valid), 32'(c >= 2));
                check("rdata_last", 32'(rdata_last), 32'(c == BL + 1));
                if (c <= BL) check("rd_addr", 32'(sram_addr), 32'(ref_addr(base, c - 1)));
                else check("drain_addr", 32'(sram_addr), 32'd0);
                if (c >= 2) begin
                    check("rdata", 32'(rdata), 32'(ref_mem[ref_addr(base, c - 2)]));
                    if (c == 2) first = rdata;
                    if (c == BL + 1) last = rdata;
                end
                tick();
            end
            wdata_valid = 1'b0;
        end
    endtask

    typedef struct {
        bit         wr;
        logic [10:0] base;
        logic [7:0] d0;
        bit         toggle;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] f;
        logic [7:0] l;

        vecs[0] = '{wr: 1'b1, base: 11'h010, d0: 8'hA0, toggle: 1'b0, exp_first: 8'h00, exp_last: 8'h00};
        vecs[1] = '{wr: 1'b0, base: 11'h013, d0: 8'h00, toggle: 1'b0, exp_first: 8'hA3, exp_last: 8'hA2};
        vecs[2] = '{wr: 1'b1, base: 11'h105, d0: 8'h30, toggle: 1'b1, exp_first: 8'h00, exp_last: 8'h00};
        vecs[3] = '{wr: 1'b0, base: 11'h105, d0: 8'h00, toggle: 1'b0, exp_first: 8'h30, exp_last: 8'h37};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

        // Reset state, with a request present that must be ignored.
        rst         = 1'b1;
        mem_load    = 1'b1;
        req_valid   = 1'b1;
        req_wr      = 1'b1;
        req_addr    = 11'h7FF;
        wdata_valid = 1'b1;
        wdata       = 8'hEE;
        tick();
        mem_load = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rdata_last", 32'(rdata_last), 32'd0);
        check("rst_sram_wr", 32'(sram_rd_o_wr), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        tick();
        rst         = 1'b0;
        req_valid   = 1'b0;
        wdata_valid = 1'b1;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sram_addr", 32'(sram_addr), 32'd0);
        check("idle_wdata_ignored", 32'(sram_rd_o_wr), 32'd0);
        tick();
        wdata_valid = 1'b0;

        // Directed table: write, wrapped read, toggled write, read back.
        for (int i = 0; i < 4; i++) begin
            run_burst(vecs[i].wr, vecs[i].base, vecs[i].d0, vecs[i].toggle, 1'b0, f, l);
            if (!vecs[i].wr) begin
                check("tbl_first", 32'(f), 32'(vecs[i].exp_first));
                check("tbl_last", 32'(l), 32'(vecs[i].exp_last));
            end
        end
        for (int i = 0; i < 8; i++) begin
            check("mem_after_wr", 32'(mem[16 + i]), 32'(8'hA0 + 8'(i)));
        end

        // req_valid held through a read: the next read is taken only after drain.
        run_burst(1'b0, 11'h013, 8'h00, 1'b0, 1'b1, f, l);
        run_burst(1'b0, 11'h102, 8'h00, 1'b0, 1'b0, f, l);

        // Reset after read beat 3.
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 11'h010;
        #1;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check("abort_rd_valid", 32'(rdata_valid), 32'(c >= 2));
            tick();
        end
        rst = 1'b1;
        #1;
        check("abort_rd_rst_valid", 32'(rdata_valid), 32'd0);
        check("abort_rd_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_rd_busy", 32'(busy), 32'd0);
        check("abort_rd_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            check("abort_rd_no_valid", 32'(rdata_valid), 32'd0);
            check("abort_rd_no_last", 32'(rdata_last), 32'd0);
            tick();
        end

        // Reset after 4 write beats.
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 11'h20B;
        #1;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wdata_valid = 1'b1;
            wdata       = 8'hC0 + 8'(k);
            #1;
            check("abort_wr_strobe", 32'(sram_rd_o_wr), 32'd1);
            ref_mem[ref_addr(11'h20B, k)] = wdata;
            tick();
        end
        rst   = 1'b1;
        wdata = 8'hFF;
        #1;
        check("abort_wr_rst_strobe", 32'(sram_rd_o_wr), 32'd0);
        check("abort_wr_rst_ready", 32'(wdata_ready), 32'd0);
        tick();
        rst         = 1'b0;
        wdata_valid = 1'b0;
        #1;
        check("abort_wr_busy", 32'(busy), 32'd0);
        tick();
        run_burst(1'b0, 11'h208, 8'h00, 1'b0, 1'b0, f, l);

        // Randomised bursts against the reference memory.
        for (int i = 0; i < 40; i++) begin
            run_burst(1'($urandom_range(0, 1)), 11'($urandom_range(0, DEPTH - 1)),
                      8'($urandom), 1'($urandom_range(0, 1)), 1'b0, f, l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
